// File: rtl/usb_stream_bridge.sv
// Ready/valid byte-stream FIFO between the usb_uart receive and transmit pipelines,
// with push-time case transform, hold mode, fill level and a stretched activity LED.
module usb_stream_bridge #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned STRETCH = 2400000
) (
  input  logic                   clk_48mhz,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic [1:0]             mode,
  output logic [$clog2(DEPTH):0] level,
  output logic                   led_act_n
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(STRETCH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [LW-1:0]    level_next;
  logic [CW-1:0]    stretch_cnt;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] head_next;
  logic             push;
  logic             pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Upper-case transform on the low byte, applied before the word is stored
  always_comb begin
    wdata = in_data;
    if ((mode == 2'd1) && (in_data[7:0] >= 8'h61) && (in_data[7:0] <= 8'h7A)) begin
      wdata[5] = 1'b0;
    end
  end

  // Next level, read pointer and head word; a push into an empty slot becomes the head directly
  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + LW'(1);
    end else if (!push && pop) begin
      level_next = level - LW'(1);
    end
    rd_ptr_next = pop ? rd_ptr + AW'(1) : rd_ptr;
    head_next   = mem[rd_ptr_next];
    if (push && (wr_ptr == rd_ptr_next)) begin
      head_next = wdata;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (push && !reset) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      stretch_cnt <= '0;
      led_act_n   <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr    <= rd_ptr_next;
      level     <= level_next;
      in_ready  <= (level_next != LW'(DEPTH));
      out_valid <= (level_next != '0) && (mode != 2'd2);
      out_data  <= head_next;
      // LED stays low for STRETCH cycles after the most recent pop
      if (pop) begin
        stretch_cnt <= CW'(STRETCH - 1);
      end else if (stretch_cnt != '0) begin
        stretch_cnt <= stretch_cnt - CW'(1);
      end
      led_act_n <= (stretch_cnt == '0) && !pop;
    end
  end

endmodule

// File: tb/tb_usb_stream_bridge.sv
// Directed bench for usb_stream_bridge: queue-based reference model checked every cycle,
// plus hand-computed expectations for output sequences, fill levels and LED timing.
module tb_usb_stream_bridge;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned STRETCH = 4;

  logic             clk_48mhz = 1'b0;
  logic             reset     = 1'b1;
  logic [WIDTH-1:0] in_data   = '0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       mode      = 2'd0;
  logic [4:0]       level;
  logic             led_act_n;

  usb_stream_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STRETCH(STRETCH)) dut (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mode      (mode),
    .level     (level),
    .led_act_n (led_act_n)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  int checks   = 0;
  int failures = 0;

  // Reference model: stored words, mode seen at the last edge, pop history
  logic [7:0] q[$];
  logic [1:0] mode_reg = 2'd0;
  int         cyc      = 0;
  int         last_pop = 0;
  bit         have_pop = 1'b0;
  bit         armed    = 1'b0;

  logic [7:0] obs[$];
  logic [7:0] stim[$];
  int         idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: log DUT pops, advance the model, return at the following negedge
  task automatic tick();
    bit         m_ov;
    bit         m_push;
    bit         m_pop;
    logic [7:0] d;
    if (!reset && out_valid && out_ready) obs.push_back(out_data);
    m_ov   = (q.size() != 0) && (mode_reg != 2'd2);
    m_push = in_valid && (q.size() != DEPTH);
    m_pop  = m_ov && out_ready;
    d = in_data;
    if (mode == 2'd1 && d >= 8'h61 && d <= 8'h7A) d = d - 8'h20;
    @(posedge clk_48mhz);
    cyc++;
    if (reset) begin
      q.delete();
      have_pop = 1'b0;
    end else begin
      if (m_pop) begin
        void'(q.pop_front());
        have_pop = 1'b1;
        last_pop = cyc;
      end
      if (m_push) q.push_back(d);
    end
    mode_reg = mode;
    @(negedge clk_48mhz);
    armed = 1'b1;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk_48mhz) begin
    if (armed) begin
      bit exp_ov;
      bit exp_led;
      exp_ov  = (q.size() != 0) && (mode_reg != 2'd2);
      exp_led = !(have_pop && ((cyc - last_pop) < STRETCH));
      check("model_level", 32'(level), 32'(q.size()));
      check("model_in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
      check("model_out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) check("model_out_data", 32'(out_data), 32'(q[0]));
      check("model_led_act_n", 32'(led_act_n), 32'(exp_led));
    end
  end

  task automatic feed(input bit ordy, input int budget);
    bit acc;
    for (int c = 0; c < budget && idx < stim.size(); c++) begin
      in_valid  = 1'b1;
      in_data   = stim[idx];
      out_ready = ordy;
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (level == 0 && !out_valid) break;
      tick();
    end
    check("drain_empty", 32'(level), 32'd0);
  endtask

  task automatic load(input logic [7:0] a[$]);
    stim = a;
    idx  = 0;
    obs.delete();
  endtask

  task automatic check_obs(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, 32'(obs.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < obs.size(); k++) check(name, 32'(obs[k]), 32'(exp[k]));
  endtask

  initial begin
    logic [7:0] exp[$];
    logic [7:0] led_exp[5];

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_level", 32'(level), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_led", 32'(led_act_n), 32'd1);

    // Pass-through
    mode = 2'd0;
    load('{8'h41, 8'h62, 8'h7A});
    feed(1'b1, 10);
    drain(20);
    check_obs("pass_seq", '{8'h41, 8'h62, 8'h7A});

    // Upper-case transform, then reserved mode behaves as pass-through
    mode = 2'd1;
    load('{8'h61, 8'h7A, 8'h60, 8'h7B, 8'h5A});
    feed(1'b1, 10);
    drain(20);
    check_obs("upper_seq", '{8'h41, 8'h5A, 8'h60, 8'h7B, 8'h5A});
    mode = 2'd3;
    load('{8'h61, 8'h7A});
    feed(1'b1, 10);
    drain(20);
    check_obs("mode3_seq", '{8'h61, 8'h7A});

    // Overfill with back-pressure, then release
    mode = 2'd0;
    exp.delete();
    for (int k = 0; k < 20; k++) exp.push_back(8'(k));
    load(exp);
    feed(1'b0, 20);
    check("full_accepted", 32'(idx), 32'd16);
    check("full_level", 32'(level), 32'd16);
    check("full_in_ready", 32'(in_ready), 32'd0);
    feed(1'b1, 60);
    check("overfill_fed", 32'(idx), 32'd20);
    drain(40);
    check_obs("overfill_seq", exp);

    // Sustained push+pop at full, across several pointer wraps
    exp.delete();
    for (int k = 0; k < 64; k++) exp.push_back(8'(k + 8'h80));
    load(exp);
    feed(1'b0, 16);
    check("wrap_full_level", 32'(level), 32'd16);
    for (int c = 0; c < 200 && idx < stim.size(); c++) begin
      bit acc;
      in_valid  = 1'b1;
      in_data   = stim[idx];
      out_ready = 1'b1;
      acc = in_ready;
      tick();
      if (acc) idx++;
      if (idx < stim.size()) check("wrap_level_range", 32'(level >= 15 && level <= 16), 32'd1);
    end
    in_valid = 1'b0;
    check("wrap_fed", 32'(idx), 32'd64);
    drain(40);
    check_obs("wrap_seq", exp);

    // Hold mode buffers without output, release drains in order
    out_ready = 1'b1;
    mode = 2'd2;
    tick();
    load('{8'h10, 8'h20, 8'h30, 8'h40, 8'h50});
    feed(1'b1, 10);
    tick();
    check("hold_level", 32'(level), 32'd5);
    check("hold_out_valid", 32'(out_valid), 32'd0);
    mode = 2'd0;
    out_ready = 1'b0;
    tick();
    check("release_out_valid", 32'(out_valid), 32'd1);
    check("release_head", 32'(out_data), 32'h10);
    drain(20);
    check_obs("hold_seq", '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50});

    // Single pop: LED low for exactly STRETCH cycles
    load('{8'hAA});
    feed(1'b0, 4);
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    check("led_idle", 32'(led_act_n), 32'd1);
    check("led_word_ready", 32'(out_valid), 32'd1);
    led_exp = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("led_t1", 32'(led_act_n), 32'(led_exp[0]));
    for (int k = 1; k < 5; k++) begin
      tick();
      check($sformatf("led_t%0d", k + 1), 32'(led_act_n), 32'(led_exp[k]));
    end

    // Reset while holding seven words; a push offered during reset is dropped
    exp.delete();
    for (int k = 0; k < 7; k++) exp.push_back(8'(k + 8'h30));
    load(exp);
    feed(1'b0, 10);
    tick();
    check("prereset_level", 32'(level), 32'd7);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h55;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("midreset_level", 32'(level), 32'd0);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_led", 32'(led_act_n), 32'd1);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("postreset_level", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
